// File: rtl/connect_suite_adder_scheduler_pkg.sv
// Shared types for the adder scheduler: FSM encoding,
// default width and the round-robin pick helper.
package connect_suite_adder_scheduler_pkg;

  localparam int DATA_W  = 8;
  localparam int MAX_REQ = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  // First set bit at or after ptr, wrapping modulo n.
  function automatic pick_t rr_pick(
    input logic [MAX_REQ-1:0] vld,
    input logic [2:0]         ptr,
    input int                 n
  );
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (!p.found && k < n && vld[j[2:0]]) begin
        p.found = 1'b1;
        p.idx   = j[2:0];
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/connect_suite_adder_scheduler_adder.sv
// Shared adder datapath: unsigned add with carry out.
// Purely combinational; the scheduler registers the result.
module connect_suite_shared_adder #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/connect_suite_adder_scheduler.sv
// Round-robin scheduler sharing one adder between requesters.
// IDLE grants, EXEC adds, RESP holds the result until taken.
module connect_suite_adder_scheduler
  import connect_suite_adder_scheduler_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        io_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_a,
  input  logic [NUM_REQ*DATA_W-1:0] io_req_b,
  output logic [NUM_REQ-1:0]        io_req_ready,
  output logic                      io_resp_valid,
  input  logic                      io_resp_ready,
  output logic [DATA_W-1:0]         io_resp_data,
  output logic                      io_resp_carry,
  output logic [ID_W-1:0]           io_resp_id,
  output logic                      io_busy,
  output logic [CNT_W-1:0]          io_op_count
);

  state_e              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                rvld_q, rvld_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rcarry_q, rcarry_d;
  logic [ID_W-1:0]     rid_q, rid_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [MAX_REQ-1:0]  vld_pad;
  pick_t               pick;
  logic [ID_W-1:0]     g;
  logic [ID_W-1:0]     g_nxt;
  logic [DATA_W-1:0]   a_sel, b_sel;
  logic [NUM_REQ-1:0]  grant;
  logic [DATA_W-1:0]   sum;
  logic                carry;

  connect_suite_shared_adder #(
    .DATA_W (DATA_W)
  ) u_adder (
    .a_i     (a_q),
    .b_i     (b_q),
    .sum_o   (sum),
    .carry_o (carry)
  );

  // Round-robin winner and its operands.
  always_comb begin
    vld_pad = '0;
    vld_pad[NUM_REQ-1:0] = io_req_valid;
    pick  = rr_pick(vld_pad, 3'(ptr_q), NUM_REQ);
    g     = pick.idx[ID_W-1:0];
    g_nxt = (g == ID_W'(NUM_REQ - 1)) ? '0 : g + ID_W'(1);
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == g) begin
        a_sel = io_req_a[i*DATA_W +: DATA_W];
        b_sel = io_req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and datapath update for IDLE/EXEC/RESP.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    a_d      = a_q;
    b_d      = b_q;
    id_d     = id_q;
    rvld_d   = rvld_q;
    rdata_d  = rdata_q;
    rcarry_d = rcarry_q;
    rid_d    = rid_q;
    cnt_d    = cnt_q;
    grant    = '0;
    unique case (state_q)
      IDLE: begin
        if (pick.found) begin
          grant[g] = 1'b1;
          a_d      = a_sel;
          b_d      = b_sel;
          id_d     = g;
          ptr_d    = g_nxt;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rdata_d  = sum;
        rcarry_d = carry;
        rid_d    = id_q;
        rvld_d   = 1'b1;
        state_d  = RESP;
      end
      RESP: begin
        if (rvld_q && io_resp_ready) begin
          rvld_d  = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= '0;
      rvld_q   <= 1'b0;
      rdata_q  <= '0;
      rcarry_q <= 1'b0;
      rid_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      a_q      <= a_d;
      b_q      <= b_d;
      id_q     <= id_d;
      rvld_q   <= rvld_d;
      rdata_q  <= rdata_d;
      rcarry_q <= rcarry_d;
      rid_q    <= rid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign io_req_ready  = grant & {NUM_REQ{reset_n}};
  assign io_resp_valid = rvld_q;
  assign io_resp_data  = rdata_q;
  assign io_resp_carry = rcarry_q;
  assign io_resp_id    = rid_q;
  assign io_busy       = (state_q != IDLE);
  assign io_op_count   = cnt_q;

endmodule

// File: tb/tb_connect_suite_adder_scheduler.sv
// Bench for the adder scheduler: directed requests with
// a grant/response scoreboard drained by a monitor.
module tb_connect_suite_adder_scheduler;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  io_req_valid;
  logic [31:0] io_req_a;
  logic [31:0] io_req_b;
  logic [3:0]  io_req_ready;
  logic        io_resp_valid;
  logic        io_resp_ready;
  logic [7:0]  io_resp_data;
  logic        io_resp_carry;
  logic [1:0]  io_resp_id;
  logic        io_busy;
  logic [15:0] io_op_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [1:0]  exp_grant[$];
  logic [10:0] exp_resp[$];

  connect_suite_adder_scheduler dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .io_req_valid  (io_req_valid),
    .io_req_a      (io_req_a),
    .io_req_b      (io_req_b),
    .io_req_ready  (io_req_ready),
    .io_resp_valid (io_resp_valid),
    .io_resp_ready (io_resp_ready),
    .io_resp_data  (io_resp_data),
    .io_resp_carry (io_resp_carry),
    .io_resp_id    (io_resp_id),
    .io_busy       (io_busy),
    .io_op_count   (io_op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops expected grants and responses.
  always @(negedge clk) begin
    if (reset_n && io_req_ready != 4'b0) begin
      if (exp_grant.size() == 0) begin
        chk("unexpected_grant", 32'(io_req_ready), 32'h0);
      end else begin
        logic [1:0] eg;
        eg = exp_grant.pop_front();
        chk("grant", 32'(io_req_ready), 32'(4'b0001 << eg));
      end
    end
    if (reset_n && io_resp_valid && io_resp_ready) begin
      if (exp_resp.size() == 0) begin
        chk("unexpected_resp",
            32'({io_resp_carry, io_resp_data, io_resp_id}), 32'h0);
      end else begin
        logic [10:0] er;
        er = exp_resp.pop_front();
        chk("resp_data", 32'(io_resp_data), 32'(er[9:2]));
        chk("resp_carry", 32'(io_resp_carry), 32'(er[10]));
        chk("resp_id", 32'(io_resp_id), 32'(er[1:0]));
      end
    end
  end

  task automatic wait_grant(output logic [3:0] g);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (io_req_ready == 4'b0 && n < 20);
    g = io_req_ready;
    if (g == 4'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL grant_timeout: got none expected grant");
    end
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!io_resp_valid && n < 20);
    if (!io_resp_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL resp_timeout: got none expected resp");
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #3;
    chk("rst_ready", 32'(io_req_ready), 32'h0);
    chk("rst_rvalid", 32'(io_resp_valid), 32'h0);
    chk("rst_count", 32'(io_op_count), 32'h0);
    chk("rst_busy", 32'(io_busy), 32'h0);
    chk("rst_rdata", 32'({io_resp_carry, io_resp_data, io_resp_id}), 32'h0);
    step();
    step();
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  g;
    logic [10:0] held;
    int          last;
    io_req_valid  = '0;
    io_req_a      = '0;
    io_req_b      = '0;
    io_resp_ready = 1'b1;
    reset_n       = 1'b1;
    #2;
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_state",
          32'({io_busy, io_req_ready, io_resp_valid, io_op_count}), 32'h0);
    end

    // Requester 2 alone: 12 + 34.
    step();
    io_req_a[23:16] = 8'h12;
    io_req_b[23:16] = 8'h34;
    exp_grant.push_back(2'd2);
    exp_resp.push_back({1'b0, 8'h46, 2'd2});
    io_req_valid = 4'b0100;
    wait_grant(g);
    step();
    io_req_valid = 4'b0;
    @(negedge clk);
    chk("exec_ready", 32'(io_req_ready), 32'h0);
    chk("exec_busy", 32'(io_busy), 32'h1);
    chk("exec_rvalid", 32'(io_resp_valid), 32'h0);
    @(negedge clk);
    chk("resp_rvalid", 32'(io_resp_valid), 32'h1);
    @(negedge clk);
    chk("count1", 32'(io_op_count), 32'h1);
    chk("idle_busy", 32'(io_busy), 32'h0);

    // All four continuously, pointer fresh from reset.
    step();
    do_reset();
    io_req_a = {8'd3, 8'd2, 8'd1, 8'd0};
    io_req_b = {4{8'h10}};
    for (int i = 0; i < 5; i++) begin
      exp_grant.push_back(2'(i % 4));
      exp_resp.push_back({1'b0, 8'(8'h10 + (i % 4)), 2'(i % 4)});
    end
    io_req_valid = 4'b1111;
    last = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(g);
      if (i > 0) chk("grant_gap", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    step();
    io_req_valid = 4'b0;
    repeat (3) @(negedge clk);
    chk("count5", 32'(io_op_count), 32'd5);

    // Overflow on requester 1.
    step();
    io_req_a[15:8] = 8'hF0;
    io_req_b[15:8] = 8'h20;
    exp_grant.push_back(2'd1);
    exp_resp.push_back({1'b1, 8'h10, 2'd1});
    io_req_valid = 4'b0010;
    wait_grant(g);
    step();
    io_req_valid = 4'b0;
    repeat (3) @(negedge clk);
    chk("count6", 32'(io_op_count), 32'd6);

    // Backpressure on requester 0, requester 3 waiting.
    step();
    io_resp_ready = 1'b0;
    io_req_a[7:0] = 8'h7F;
    io_req_b[7:0] = 8'h01;
    io_req_a[31:24] = 8'h05;
    io_req_b[31:24] = 8'h06;
    exp_grant.push_back(2'd0);
    exp_resp.push_back({1'b0, 8'h80, 2'd0});
    io_req_valid = 4'b0001;
    wait_grant(g);
    step();
    exp_grant.push_back(2'd3);
    exp_resp.push_back({1'b0, 8'h0B, 2'd3});
    io_req_valid = 4'b1000;
    wait_resp();
    held = {io_resp_carry, io_resp_data, io_resp_id};
    chk("bp_value", 32'(held), 32'({1'b0, 8'h80, 2'd0}));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold",
          32'({io_resp_valid, io_resp_carry, io_resp_data, io_resp_id}),
          32'({1'b1, held}));
      chk("bp_noready", 32'(io_req_ready), 32'h0);
    end
    step();
    io_resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("regrant", 32'(io_req_ready), 32'h8);
    chk("count7", 32'(io_op_count), 32'd7);
    chk("kept_data", 32'(io_resp_data), 32'h80);
    step();
    io_req_valid = 4'b0;
    repeat (3) @(negedge clk);
    chk("count8", 32'(io_op_count), 32'd8);

    // Reset while in EXEC discards the operation.
    step();
    io_req_a[23:16] = 8'h01;
    io_req_b[23:16] = 8'h01;
    exp_grant.push_back(2'd2);
    io_req_valid = 4'b0100;
    wait_grant(g);
    step();
    io_req_valid = 4'b0;
    chk("pre_rst_busy", 32'(io_busy), 32'h1);
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("post_rst",
          32'({io_busy, io_resp_valid, io_op_count}), 32'h0);
    end
    step();
    io_req_a[15:8] = 8'h22;
    io_req_b[15:8] = 8'h33;
    exp_grant.push_back(2'd1);
    exp_resp.push_back({1'b0, 8'h55, 2'd1});
    io_req_valid = 4'b1010;
    wait_grant(g);
    step();
    io_req_valid = 4'b0;
    repeat (3) @(negedge clk);
    chk("count_after_rst", 32'(io_op_count), 32'd1);
    chk("grants_drained", 32'(exp_grant.size()), 32'd0);
    chk("resps_drained", 32'(exp_resp.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
